// File: rtl/pred_argmax.sv
// Argmax over per-class spike counts: snapshots all counts on a rising edge of go,
// scans one class per cycle (lowest index wins ties) and holds the result until accepted.
module pred_argmax #(
  parameter int NUM_CLASSES = 11,
  parameter int CNT_W       = 8,
  parameter int IDX_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [CNT_W-1:0] pred_in [NUM_CLASSES],
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] class_idx,
  output logic [CNT_W-1:0] max_count,
  output logic             tie,
  output logic             no_spike,
  output logic             busy
);

  // Scan index must reach NUM_CLASSES itself, so it may be wider than the class index.
  localparam int SCAN_W = $clog2(NUM_CLASSES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e               state_q;
  logic                 go_q;
  logic                 armed_q;
  logic [CNT_W-1:0]     snap_q [NUM_CLASSES];
  logic [SCAN_W-1:0]    scan_idx_q;
  logic [IDX_W-1:0]     best_idx_q;
  logic [CNT_W-1:0]     best_cnt_q;
  logic                 tie_r_q;
  logic                 out_valid_q;
  logic [IDX_W-1:0]     class_idx_q;
  logic [CNT_W-1:0]     max_count_q;
  logic                 tie_q;
  logic                 no_spike_q;
  logic                 busy_q;

  logic                 start_s;
  logic [CNT_W-1:0]     cur_cnt_s;

  // armed_q masks the first edge after reset so a go already high is not taken as a start.
  assign start_s = go & ~go_q & armed_q;

  // Snapshot entry under comparison; the out-of-range slot only occurs on the final SCAN cycle.
  always_comb begin
    cur_cnt_s = '0;
    if (scan_idx_q < SCAN_W'(NUM_CLASSES)) begin
      cur_cnt_s = snap_q[scan_idx_q];
    end else begin
      cur_cnt_s = '0;
    end
  end

  // Control FSM with snapshot, running best and registered result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      go_q        <= 1'b0;
      armed_q     <= 1'b0;
      snap_q      <= '{default: '0};
      scan_idx_q  <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      tie_r_q     <= 1'b0;
      out_valid_q <= 1'b0;
      class_idx_q <= '0;
      max_count_q <= '0;
      tie_q       <= 1'b0;
      no_spike_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      go_q    <= go;
      armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_s) begin
            snap_q     <= pred_in;
            best_idx_q <= '0;
            best_cnt_q <= pred_in[0];
            tie_r_q    <= 1'b0;
            scan_idx_q <= SCAN_W'(1);
            busy_q     <= 1'b1;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (scan_idx_q == SCAN_W'(NUM_CLASSES)) begin
            class_idx_q <= best_idx_q;
            max_count_q <= best_cnt_q;
            tie_q       <= tie_r_q;
            no_spike_q  <= (best_cnt_q == '0);
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            if (cur_cnt_s > best_cnt_q) begin
              best_idx_q <= IDX_W'(scan_idx_q);
              best_cnt_q <= cur_cnt_s;
              tie_r_q    <= 1'b0;
            end else if (cur_cnt_s == best_cnt_q) begin
              tie_r_q <= 1'b1;
            end
            scan_idx_q <= scan_idx_q + SCAN_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign class_idx = class_idx_q;
  assign max_count = max_count_q;
  assign tie       = tie_q;
  assign no_spike  = no_spike_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pred_argmax.sv
// Directed bench for pred_argmax: latency, argmax/tie/zero cases, backpressure with
// snapshot isolation, and mid-scan reset.
module tb_pred_argmax;

  logic       clock = 1'b0;
  logic       reset;
  logic       go;
  logic [7:0] pred_in [11];
  logic       out_ready;
  logic       out_valid;
  logic [3:0] class_idx;
  logic [7:0] max_count;
  logic       tie;
  logic       no_spike;
  logic       busy;

  int checks = 0;
  int errors = 0;

  pred_argmax #(.NUM_CLASSES(11), .CNT_W(8), .IDX_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .pred_in   (pred_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .class_idx (class_idx),
    .max_count (max_count),
    .tie       (tie),
    .no_spike  (no_spike),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start from go low, expect out_valid exactly 11 cycles after the start edge,
  // then handshake with go still high and confirm no second result appears.
  task automatic run_scan(input string tag, input int e_idx, input int e_max,
                          input bit e_tie, input bit e_ns);
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    repeat (10) tick();
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_idx"}, 32'(class_idx), 32'(e_idx));
    chk({tag, "_max"}, 32'(max_count), 32'(e_max));
    chk({tag, "_tie"}, 32'(tie), 32'(e_tie));
    chk({tag, "_nospike"}, 32'(no_spike), 32'(e_ns));
    tick();
    chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_hs_busy"}, 32'(busy), 32'd0);
    chk({tag, "_hs_keep"}, 32'(class_idx), 32'(e_idx));
    repeat (14) tick();
    chk({tag, "_once"}, 32'(out_valid | busy), 32'd0);
    go = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    go        = 1'b0;
    out_ready = 1'b1;
    pred_in   = '{default: 8'd0};
    repeat (2) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(class_idx), 32'd0);
    chk("rst_max", 32'(max_count), 32'd0);
    chk("rst_flags", 32'({tie, no_spike}), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    pred_in = '{8'd3, 8'd9, 8'd1, 8'd0, 8'd5, 8'd2, 8'd8, 8'd0, 8'd0, 8'd4, 8'd7};
    run_scan("unique", 1, 9, 1'b0, 1'b0);

    pred_in = '{8'd10, 8'd20, 8'd200, 8'd5, 8'd0, 8'd199, 8'd1, 8'd200, 8'd3, 8'd4, 8'd100};
    run_scan("tie", 2, 200, 1'b1, 1'b0);

    pred_in = '{default: 8'd0};
    run_scan("zero", 0, 0, 1'b1, 1'b1);

    pred_in = '{8'd254, 8'd254, 8'd254, 8'd254, 8'd254, 8'd254,
                8'd254, 8'd254, 8'd254, 8'd254, 8'd255};
    run_scan("last", 10, 255, 1'b0, 1'b0);

    // Backpressure: counts change right after the start edge and go re-toggles while held.
    out_ready = 1'b0;
    pred_in = '{8'd3, 8'd9, 8'd1, 8'd0, 8'd5, 8'd2, 8'd8, 8'd0, 8'd0, 8'd4, 8'd7};
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    pred_in = '{default: 8'd250};
    repeat (11) tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_snap_idx", 32'(class_idx), 32'd1);
    chk("bp_snap_max", 32'(max_count), 32'd9);
    for (int i = 0; i < 20; i++) begin
      go = i[0];
      pred_in[i % 11] = 8'(i * 13);
      tick();
    end
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_busy", 32'(busy), 32'd1);
    chk("bp_hold_idx", 32'(class_idx), 32'd1);
    chk("bp_hold_max", 32'(max_count), 32'd9);
    chk("bp_hold_tie", 32'(tie), 32'd0);
    go = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_hs_valid", 32'(out_valid), 32'd0);
    chk("bp_hs_busy", 32'(busy), 32'd0);
    repeat (15) tick();
    chk("bp_no_second", 32'(out_valid | busy), 32'd0);

    // Reset five cycles into a scan with go held high.
    pred_in = '{8'd3, 8'd9, 8'd1, 8'd0, 8'd5, 8'd2, 8'd8, 8'd0, 8'd0, 8'd4, 8'd7};
    go = 1'b1;
    tick();
    repeat (5) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_idx", 32'(class_idx), 32'd0);
    chk("mr_max", 32'(max_count), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) tick();
    chk("mr_no_restart_valid", 32'(out_valid), 32'd0);
    chk("mr_no_restart_busy", 32'(busy), 32'd0);
    run_scan("after_rst", 1, 9, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pred_argmax.md
PRED_ARGMAX -- requirements
Module: pred_argmax

Interface
REQ-001 Parameter NUM_CLASSES, default 11: number of output classes scanned.
REQ-002 Parameter CNT_W, default 8: width of each spike-count input.
REQ-003 Parameter IDX_W, default 4: width of the class index, sized so that 2^IDX_W >= NUM_CLASSES.
REQ-004 Single clock and asynchronous active-high reset; the ports are named clock and reset as elsewhere in the codebase.
REQ-005 Port clock, input, 1: rising-edge clock.
REQ-006 Port reset, input, 1: asynchronous, active-high clear of all state.
REQ-007 Port go, input, 1: level done flag from the upstream spike counter; a start is its rising edge.
REQ-008 Port pred_in, input, CNT_W x NUM_CLASSES unpacked: per-class spike counts, valid while go is high.
REQ-009 Port out_ready, input, 1: downstream accepts the result.
REQ-010 Port out_valid, output, 1: the result is held and stable.
REQ-011 Port class_idx, output, IDX_W: index of the winning class.
REQ-012 Port max_count, output, CNT_W: spike count of the winning class.
REQ-013 Port tie, output, 1: another class equals max_count.
REQ-014 Port no_spike, output, 1: all counts are zero.
REQ-015 Port busy, output, 1: state is not IDLE.

Function
REQ-016 FSM states: IDLE, SCAN, HOLD; one-hot or binary encoding is implementer's choice.
REQ-017 go is registered once into go_q; start = go & ~go_q.
REQ-018 IDLE->SCAN on start: all NUM_CLASSES counts are snapshotted into an internal register on the same edge; best_idx=0, best_cnt=pred_in[0], tie_r=0, scan index=1.
REQ-019 SCAN: one class is compared per cycle, indices 1..NUM_CLASSES-1 in ascending order, using the snapshot only; pred_in is ignored after the snapshot.
REQ-020 Compare rule, count strictly greater: that class becomes best and tie_r clears.
REQ-021 Compare rule, count equal: best is unchanged (lowest index wins) and tie_r is set.
REQ-022 Compare rule, count less: no change.
REQ-023 Comparison is unsigned CNT_W; no saturation or widening is needed.
REQ-024 After index NUM_CLASSES-1 is compared: SCAN->HOLD, and out_valid rises on the next edge; latency from the start edge to out_valid=1 is NUM_CLASSES cycles (11 at default).
REQ-025 HOLD: class_idx, max_count, tie and no_spike are stable while out_valid=1.
REQ-026 no_spike = (best_cnt==0); when no_spike=1, class_idx=0 and tie=1 (for NUM_CLASSES>1).
REQ-027 HOLD->IDLE on an edge with out_valid & out_ready; out_valid drops on that edge, while the result outputs keep their last value until the next start.
REQ-028 start while busy=1 is ignored and not queued; go must fall and rise again to restart.
REQ-029 A start in the same cycle as the HOLD->IDLE handshake is ignored; the next start may come one cycle after IDLE is re-entered.
REQ-030 go held high continuously produces exactly one result.
REQ-031 NUM_CLASSES=1: SCAN lasts one cycle with no comparisons; result is idx 0, tie=0.

Reset
REQ-032 On reset assertion, state=IDLE and outputs go immediately to: out_valid=0, busy=0, class_idx=0, max_count=0, tie=0, no_spike=0; go_q=0 and the snapshot is cleared.
REQ-033 Reset mid-SCAN or mid-HOLD aborts the scan without producing a result.
REQ-034 After release, if go is still high, go_q captures 1 with no start; a fresh rising edge of go is required.

Verification
REQ-035 Unique max: counts {3,9,1,0,5,2,8,0,0,4,7}, go 0->1, out_ready=1 -> out_valid at 11 cycles, class_idx=1, max_count=9, tie=0, no_spike=0.
REQ-036 Tie: counts with classes 2 and 7 both =200 and all others <200 -> class_idx=2, max_count=200, tie=1.
REQ-037 All zero counts -> class_idx=0, max_count=0, tie=1, no_spike=1.
REQ-038 Backpressure and snapshot: out_ready=0 for 20 cycles while pred_in changes and go re-toggles -> outputs unchanged, busy=1, no second result; out_ready=1 -> one handshake, then IDLE.
REQ-039 Reset at scan cycle 5 with go held high -> all outputs 0 immediately; no out_valid after release until go falls and rises.
REQ-040 Max at last index (class 10 = 255, others 254) -> class_idx=10, max_count=255, tie=0; checks the final compare and unsigned full-scale handling.
